uart_tx_frame: RTL

Parametrised UART transmitter. It serialises one DATA_BITS-wide word per valid/ready handshake into a start/data/[parity]/stop frame on tx. Bit order, bit period, stop-bit count and parity are configurable. It sits between a byte source (FIFO or host logic) and the serial pin, and supports back-to-back frames with no idle gap.

---
 rtl/uart_tx_frame_if.sv | 12 +
 rtl/uart_tx_frame.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Word handshake between a byte source (master) and the UART transmitter (slave).
// A word moves on any cycle where data_valid && data_ready.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per handshake -> start/data/[parity]/stop frame on tx.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_frame_if.slave     s,
  output logic               tx,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (MSB_FIRST != 0 && MSB_FIRST != 1) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]        data_idx_q, data_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 hs, bit_end, last_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_idx_d = data_idx_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    hs      = s.data_valid && ready_q;
    bit_end = (bit_cnt_q == BIT_LAST);

    if (state_q != IDLE)
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d   = START;
          bit_cnt_d = '0;
          shreg_d   = s.data;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^s.data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d    = DATA;
          data_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (MSB_FIRST != 0)
            shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
          else
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          if (data_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            stop_cnt_d = 1'b0;
          end else begin
            data_idx_d = data_idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            // A word offered in the last stop cycle starts the next frame with no idle gap.
            if (hs) begin
              state_d   = START;
              shreg_d   = s.data;
`ifdef UART_TX_PARITY_EN
              parity_d  = (^s.data) ^ 1'(PARITY_ODD);
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = (MSB_FIRST != 0) ? shreg_d[DATA_BITS-1] : shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    last_d  = (state_d == STOP) && (stop_cnt_d == STOP_LAST) && (bit_cnt_d == BIT_LAST);
    done_d  = last_d;
    ready_d = (state_d == IDLE) || last_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      data_idx_q <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_idx_q <= data_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign s.data_ready = ready_q;
endmodule
